ptp_tx_ts_tracker: RTL and testbench



---
 rtl/ptp_ts_tracker_pkg.sv | 21 ++
 rtl/ptp_ts_compl_fifo.sv | 53 +++++
 rtl/ptp_tx_ts_tracker.sv | 188 ++++++++++++++++++
 tb/tb_ptp_tx_ts_tracker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_ts_tracker_pkg.sv
// rtl/ptp_ts_tracker_pkg.sv - shared types and constants for the PTP TX timestamp tracker
package ptp_ts_tracker_pkg;

    localparam int FP_W = 20;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } entry_state_t;

    localparam logic [1:0] TS_OK      = 2'b00;
    localparam logic [1:0] TS_TIMEOUT = 2'b01;

    typedef struct packed {
        logic [FP_W-1:0] fp;
        logic [95:0]     data;
        logic [1:0]      status;
    } compl_t;

endpackage

// File: rtl/ptp_ts_compl_fifo.sv
// rtl/ptp_ts_compl_fifo.sv - show-ahead completion queue, depth 2**AW
module ptp_ts_compl_fifo
    import ptp_ts_tracker_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   s_tvalid,
    input  compl_t s_tdata,
    output logic   m_tvalid,
    input  logic   m_tready,
    output compl_t m_tdata
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    compl_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign m_tvalid = (count != '0);
    assign pop      = m_tvalid & m_tready;
    assign push     = s_tvalid & (count != FULL);
    // Gate the head so the output reads zero while empty and in reset.
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ptp_tx_ts_tracker.sv
// rtl/ptp_tx_ts_tracker.sv - PTP TX fingerprint allocator and timestamp completion tracker
// Optional timeout scanner compiled in with PTP_TS_TIMEOUT_EN.
module ptp_tx_ts_tracker
    import ptp_ts_tracker_pkg::*;
#(
    parameter int FP_WIDTH       = 8,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic            clk_clk,
    input  logic            reset_reset,
    input  logic            alloc_valid,
    output logic            alloc_ready,
    output logic [FP_W-1:0] alloc_fingerprint,
    output logic            ts_req_valid,
    output logic [FP_W-1:0] ts_req_fingerprint,
    input  logic            ts_valid,
    input  logic [FP_W-1:0] ts_fingerprint,
    input  logic [95:0]     ts_data,
    output logic            compl_valid,
    input  logic            compl_ready,
    output logic [FP_W-1:0] compl_fingerprint,
    output logic [95:0]     compl_data,
    output logic [1:0]      compl_status,
    output logic [TAG_W:0]  outstanding_count,
    output logic [15:0]     timeout_count,
    output logic [15:0]     stray_count
);
    localparam int N     = 2 ** TAG_W;
    localparam int GEN_W = FP_WIDTH - TAG_W;
    localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

    if (TAG_W >= FP_WIDTH) begin : g_bad_tag_w
        $error("TAG_W must be smaller than FP_WIDTH");
    end
    if (TIMEOUT_CYCLES >= 2 ** 24) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be below 2**24");
    end

    function automatic logic [FP_W-1:0] make_fp(input logic [GEN_W-1:0] g, input logic [TAG_W-1:0] t);
        logic [FP_W-1:0] fp;
        fp = '0;
        fp[FP_WIDTH-1:0] = {g, t};
        return fp;
    endfunction

    entry_state_t     state [N];
    logic [GEN_W-1:0] gen   [N];

    logic [TAG_W-1:0] alloc_idx;
    logic             any_free;
    logic             alloc_fire;
    logic [TAG_W-1:0] ts_tag;
    logic [GEN_W-1:0] ts_gen;
    logic             ts_hit;
    logic             to_fire;
    logic [TAG_W-1:0] to_tag;
    logic             push_valid;
    logic             pop;
    compl_t           push_data;
    compl_t           head;

    // Descending scan so the lowest-index FREE entry wins.
    always_comb begin
        alloc_idx = '0;
        any_free  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (state[i] == FREE) begin
                alloc_idx = TAG_W'(i);
                any_free  = 1'b1;
            end
        end
    end

    assign alloc_ready       = any_free & ~reset_reset;
    assign alloc_fire        = alloc_valid & alloc_ready;
    assign alloc_fingerprint = alloc_ready ? make_fp(gen[alloc_idx] + GEN_ONE, alloc_idx) : '0;

    assign ts_tag = ts_fingerprint[TAG_W-1:0];
    assign ts_gen = ts_fingerprint[FP_WIDTH-1:TAG_W];
    assign ts_hit = ts_valid && (ts_fingerprint[FP_W-1:FP_WIDTH] == '0)
                    && (state[ts_tag] == PEND) && (gen[ts_tag] == ts_gen);

    assign push_valid = ts_hit | to_fire;
    always_comb begin
        if (ts_hit) begin
            push_data = compl_t'{fp: ts_fingerprint, data: ts_data, status: TS_OK};
        end else begin
            push_data = compl_t'{fp: make_fp(gen[to_tag], to_tag), data: 96'd0, status: TS_TIMEOUT};
        end
    end

    ptp_ts_compl_fifo #(.AW(TAG_W)) u_compl_fifo (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .s_tvalid (push_valid),
        .s_tdata  (push_data),
        .m_tvalid (compl_valid),
        .m_tready (compl_ready),
        .m_tdata  (head)
    );

    assign compl_fingerprint = head.fp;
    assign compl_data        = head.data;
    assign compl_status      = head.status;
    assign pop               = compl_valid & compl_ready;

    // Alloc, match/timeout and pop each act on a different entry state, so at most one fires per entry.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= FREE;
                gen[i]   <= '0;
            end
            ts_req_valid       <= 1'b0;
            ts_req_fingerprint <= '0;
            stray_count        <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (alloc_fire && alloc_idx == TAG_W'(i)) begin
                    state[i] <= PEND;
                    gen[i]   <= gen[i] + GEN_ONE;
                end else if (ts_hit && ts_tag == TAG_W'(i)) begin
                    state[i] <= DONE;
                end else if (to_fire && to_tag == TAG_W'(i)) begin
                    state[i] <= DONE;
                end else if (pop && compl_fingerprint[TAG_W-1:0] == TAG_W'(i)) begin
                    state[i] <= FREE;
                end
            end
            ts_req_valid       <= alloc_fire;
            ts_req_fingerprint <= alloc_fire ? alloc_fingerprint : '0;
            if (ts_valid && !ts_hit && stray_count != 16'hFFFF) begin
                stray_count <= stray_count + 16'd1;
            end
        end
    end

    always_comb begin
        outstanding_count = '0;
        for (int i = 0; i < N; i++) begin
            if (state[i] != FREE) outstanding_count = outstanding_count + (TAG_W + 1)'(1);
        end
    end

`ifdef PTP_TS_TIMEOUT_EN
    localparam logic [23:0] TO_LIMIT = 24'(TIMEOUT_CYCLES);

    logic [23:0]      now;
    logic [23:0]      t_alloc [N];
    logic [TAG_W-1:0] scan_idx;
    logic [23:0]      age;
    logic             due;

    assign age     = now - t_alloc[scan_idx];
    assign due     = (state[scan_idx] == PEND) && (age >= TO_LIMIT);
    assign to_fire = due & ~ts_hit;
    assign to_tag  = scan_idx;

    always_ff @(posedge clk_clk) begin
        if (alloc_fire) begin
            t_alloc[alloc_idx] <= now;
        end
    end

    // A due entry blocked by a ts match keeps the scanner parked on it for a retry.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            now           <= '0;
            scan_idx      <= '0;
            timeout_count <= '0;
        end else begin
            now <= now + 24'd1;
            if (!(due && ts_hit)) begin
                scan_idx <= scan_idx + TAG_W'(1);
            end
            if (to_fire && timeout_count != 16'hFFFF) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end
`else
    assign to_fire       = 1'b0;
    assign to_tag        = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_ptp_tx_ts_tracker.sv
// tb/tb_ptp_tx_ts_tracker.sv - scoreboard bench for ptp_tx_ts_tracker
module tb_ptp_tx_ts_tracker;
    import ptp_ts_tracker_pkg::*;

    localparam int FP_WIDTH       = 8;
    localparam int TAG_W          = 4;
    localparam int TIMEOUT_CYCLES = 100;

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic [19:0]       alloc_fingerprint;
    logic              ts_req_valid;
    logic [19:0]       ts_req_fingerprint;
    logic              ts_valid = 1'b0;
    logic [19:0]       ts_fingerprint = '0;
    logic [95:0]       ts_data = '0;
    logic              compl_valid;
    logic              compl_ready = 1'b0;
    logic [19:0]       compl_fingerprint;
    logic [95:0]       compl_data;
    logic [1:0]        compl_status;
    logic [TAG_W:0]    outstanding_count;
    logic [15:0]       timeout_count;
    logic [15:0]       stray_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int          req_seen = 0;
    int          cyc = 0;
    compl_t      exp_q[$];
    logic [19:0] req_q[$];

    ptp_tx_ts_tracker #(
        .FP_WIDTH       (FP_WIDTH),
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_clk            (clk_clk),
        .reset_reset        (reset_reset),
        .alloc_valid        (alloc_valid),
        .alloc_ready        (alloc_ready),
        .alloc_fingerprint  (alloc_fingerprint),
        .ts_req_valid       (ts_req_valid),
        .ts_req_fingerprint (ts_req_fingerprint),
        .ts_valid           (ts_valid),
        .ts_fingerprint     (ts_fingerprint),
        .ts_data            (ts_data),
        .compl_valid        (compl_valid),
        .compl_ready        (compl_ready),
        .compl_fingerprint  (compl_fingerprint),
        .compl_data         (compl_data),
        .compl_status       (compl_status),
        .outstanding_count  (outstanding_count),
        .timeout_count      (timeout_count),
        .stray_count        (stray_count)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= reset_reset ? 0 : cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: request strobes and completions are compared against the scoreboard queues.
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (ts_req_valid) begin
                req_seen++;
                if (req_q.size() == 0) check_val("ts_req_extra", ts_req_fingerprint, '1);
                else check_val("ts_req_fp", ts_req_fingerprint, req_q.pop_front());
            end
            if (compl_valid && compl_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("compl_extra", compl_fingerprint, '1);
                end else begin
                    compl_t e;
                    e = exp_q.pop_front();
                    check_val("compl_fp", compl_fingerprint, e.fp);
                    check_val("compl_data", compl_data, e.data);
                    check_val("compl_status", compl_status, e.status);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid = 1'b0; ts_valid = 1'b0; ts_fingerprint = '0; ts_data = '0; compl_ready = 1'b0;
        reset_reset = 1'b1;
        tick(2);
        exp_q.delete();
        req_q.delete();
        reset_reset = 1'b0;
        #1;
    endtask

    task automatic alloc_one(input logic [19:0] exp_fp);
        alloc_valid = 1'b1;
        #1;
        check_val("alloc_ready", alloc_ready, 1);
        check_val("alloc_fp", alloc_fingerprint, exp_fp);
        req_q.push_back(exp_fp);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic ts_send(input logic [19:0] fp, input logic [95:0] d, input bit hit);
        ts_valid = 1'b1; ts_fingerprint = fp; ts_data = d;
        if (hit) exp_q.push_back(compl_t'{fp: fp, data: d, status: TS_OK});
        tick();
        ts_valid = 1'b0; ts_fingerprint = '0; ts_data = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        // Reset values
        tick(2);
        check_val("rst_alloc_ready", alloc_ready, 0);
        check_val("rst_ts_req_valid", ts_req_valid, 0);
        check_val("rst_compl_valid", compl_valid, 0);
        check_val("rst_compl_data", compl_data, 0);
        check_val("rst_outstanding", outstanding_count, 0);
        check_val("rst_stray", stray_count, 0);
        check_val("rst_timeout", timeout_count, 0);

        // Fill all 16 tags, complete out of order with the consumer stalled, then drain
        do_reset();
        for (int i = 0; i < 16; i++) alloc_one(20'h00010 + 20'(i));
        check_val("full_alloc_ready", alloc_ready, 0);
        check_val("full_outstanding", outstanding_count, 16);
        tick();
        check_val("ts_req_count", req_seen, 16);
        check_val("ts_req_idle", ts_req_valid, 0);
        for (int i = 15; i >= 0; i--) ts_send(20'h00010 + 20'(i), 96'hD00D_0000 + 96'(i * 7), 1'b1);
        check_val("q_full_valid", compl_valid, 1);
        check_val("q_full_head", compl_fingerprint, 20'h0001F);
        check_val("q_full_alloc_ready", alloc_ready, 0);
        tick(3);
        check_val("q_hold_head", compl_fingerprint, 20'h0001F);
        check_val("q_hold_data", compl_data, 96'hD00D_0000 + 96'(15 * 7));
        compl_ready = 1'b1;
        wait_drain("drain_all", 40);
        tick();
        check_val("drained_outstanding", outstanding_count, 0);
        check_val("drained_alloc_fp", alloc_fingerprint, 20'h00020);
        compl_ready = 1'b0;

        // Single hit: completion on the cycle after the ts return
        do_reset();
        alloc_one(20'h00010);
        ts_send(20'h00010, 96'h1234, 1'b1);
        check_val("hit_compl_valid", compl_valid, 1);
        check_val("hit_compl_fp", compl_fingerprint, 20'h00010);
        check_val("hit_compl_data", compl_data, 96'h1234);
        check_val("hit_compl_status", compl_status, 2'b00);
        compl_ready = 1'b1;
        tick();
        compl_ready = 1'b0;
        check_val("hit_outstanding", outstanding_count, 0);
        check_val("hit_next_fp", alloc_fingerprint, 20'h00020);

        // Strays: wrong gen, nonzero upper bits, FREE tag
        do_reset();
        alloc_one(20'h00010);
        ts_send(20'h00020, 96'hAA, 1'b0);
        ts_send(20'h10010, 96'hBB, 1'b0);
        check_val("stray_two", stray_count, 2);
        ts_send(20'h00011, 96'hCC, 1'b0);
        tick();
        check_val("stray_three", stray_count, 3);
        check_val("stray_no_compl", compl_valid, 0);
        check_val("stray_outstanding", outstanding_count, 1);
        compl_ready = 1'b1;
        ts_send(20'h00010, 96'h55, 1'b1);
        wait_drain("stray_drain", 10);
        compl_ready = 1'b0;

        // A tag freed by a pop is not allocatable in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) alloc_one(20'h00010 + 20'(i));
        ts_send(20'h00010, 96'h7, 1'b1);
        alloc_valid = 1'b1;
        compl_ready = 1'b1;
        #1;
        check_val("pop_cycle_alloc_ready", alloc_ready, 0);
        tick();
        check_val("after_pop_alloc_ready", alloc_ready, 1);
        check_val("after_pop_alloc_fp", alloc_fingerprint, 20'h00020);
        req_q.push_back(20'h00020);
        tick();
        alloc_valid = 1'b0;
        compl_ready = 1'b0;
        check_val("after_pop_outstanding", outstanding_count, 16);
        ts_send(20'h00013, 96'h99, 1'b1);

        // Reset mid-operation discards entries and queued completions
        do_reset();
        check_val("midrst_compl_valid", compl_valid, 0);
        check_val("midrst_outstanding", outstanding_count, 0);
        check_val("midrst_alloc_fp", alloc_fingerprint, 20'h00010);

`ifdef PTP_TS_TIMEOUT_EN
        begin
            int k;
            int na;
            int target;
            // Unanswered request times out with zero data
            do_reset();
            compl_ready = 1'b1;
            alloc_one(20'h00010);
            exp_q.push_back(compl_t'{fp: 20'h00010, data: 96'd0, status: TS_TIMEOUT});
            k = 0;
            while (exp_q.size() != 0 && k < 130) begin
                tick();
                k++;
            end
            check_val("timeout_seen", exp_q.size(), 0);
            check_val("timeout_latency", k <= TIMEOUT_CYCLES + 17, 1);
            check_val("timeout_count_one", timeout_count, 1);

            // Match and scanner-due timeout on tag 3 in the same cycle: match wins
            do_reset();
            compl_ready = 1'b1;
            for (int i = 0; i < 3; i++) alloc_one(20'h00010 + 20'(i));
            na = cyc;
            alloc_one(20'h00013);
            for (int i = 0; i < 3; i++) ts_send(20'h00010 + 20'(i), 96'h300 + 96'(i), 1'b1);
            target = na + TIMEOUT_CYCLES;
            while ((target % 16) != 3) target++;
            k = 0;
            while (cyc < target && k < 200) begin
                tick();
                k++;
            end
            check_val("race_reached", cyc, target);
            ts_send(20'h00013, 96'hFACE, 1'b1);
            tick(3);
            check_val("race_timeout_count", timeout_count, 0);
            check_val("race_stray_count", stray_count, 0);
            wait_drain("race_drain", 5);
            compl_ready = 1'b0;
        end
`endif

        tick(2);
        check_val("scoreboard_empty", exp_q.size(), 0);
        check_val("req_queue_empty", req_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
